collector_6_to_1_7bits: RTL
===========================

Name: collector_6_to_1_7bits

Overview:
- Serialises six parallel DATA_WIDTH-bit lanes onto one output stream, in lane order 1 to 6.
- It is the return path for the 1-to-6 per-bit demultiplexer fan-out. It gathers the six per-channel results and presents them on one shared bus, tagged with the lane index the demux `sel` uses.
- Valid/ready handshake on both sides; one six-word frame is buffered at a time.

Parameters:
- DATA_WIDTH, 7, width of each lane and of `dout`.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- din_1 .. din_6  input  DATA_WIDTH each  lane inputs; lane k maps to demux `dout_k`
- in_valid  input  1  all six lanes hold valid data this cycle
- in_ready  output  1  collector accepts a frame this cycle
- dout  output  DATA_WIDTH  serialised word
- dout_sel  output  3  lane index of `dout`: 3'd0 for din_1 through 3'd5 for din_6 (same encoding as demux `sel`)
- dout_valid  output  1  `dout`, `dout_sel` and `dout_last` are valid
- dout_last  output  1  high on the din_6 beat of each frame
- dout_ready  input  1  downstream accepts the current word

Behaviour:
- Clocking and reset:
  - All state is synchronous to `clk`.
  - While `reset` is high at a rising edge: state = IDLE; `dout_valid`=0, `dout_last`=0, `dout`=0, `dout_sel`=0, capture registers cleared.
  - In reset, `in_ready` reads 0.
  - Reset mid-frame discards the remaining beats; no partial frame is resumed.
- Input handshake:
  - A frame transfers on a cycle where `in_valid` && `in_ready`.
  - The rising edge of that cycle loads all six lanes into six DATA_WIDTH-bit capture registers.
  - Lanes are never sampled at any other time.
- States:
  - IDLE: `in_ready`=1, `dout_valid`=0. On frame accept, go to SEND with index=0.
  - SEND: `dout_valid`=1, `dout`=capture[index], `dout_sel`=index, `dout_last`=(index==5).
    - Output beat: `dout_valid` && `dout_ready`.
    - On a beat with index<5: index increments.
    - On a beat with index==5 and no new frame accepted: go to IDLE.
- Back-to-back frames:
  - `in_ready` = (state==IDLE) || (state==SEND && index==5 && `dout_ready`). This is the only combinational path from `dout_ready` to `in_ready`.
  - If a frame is accepted on the final beat, the capture registers reload, index=0 and state stays SEND. No idle bubble.
- Output timing and stability:
  - `dout`, `dout_sel`, `dout_valid` and `dout_last` are registered or decoded only from registers; there is no combinational path from any `din`.
  - Latency: the first word appears the cycle after frame accept.
  - Throughput: 1 word/cycle while `dout_ready`=1, so a full frame takes 6 cycles.
- Backpressure:
  - While `dout_valid`=1 and `dout_ready`=0, `dout`, `dout_sel` and `dout_last` hold stable and index does not change.
  - `in_ready`=0 for the whole of SEND except the final accepted beat.
  - Input changes while `in_ready`=0 are ignored.
- Index rules:
  - index is a 3-bit counter with legal values 0..5.
  - It wraps 5 to 0 only through frame reload or IDLE.
  - Values 6 and 7 are unreachable; if ever decoded, treat as IDLE.
- Width:
  - Data is passed bit-exact, with no arithmetic or sign handling.
  - Bit i of `dout` on lane k's beat equals bit i of `din_k` at capture.

Test Plan:
- Reset values: assert `reset` 3 cycles with `in_valid`=1 -> `dout_valid`=0, `in_ready`=0, `dout`=0. Release -> `in_ready`=1 the next cycle.
- Single frame, no backpressure: `din_1`..`din_6` = 7'h01,7'h12,7'h23,7'h34,7'h45,7'h7F, one `in_valid` pulse, `dout_ready`=1 -> 6 consecutive beats in that order, `dout_sel` 0..5, `dout_last` only on the 7'h7F beat; then IDLE, `in_ready`=1.
- Backpressure: same frame, `dout_ready` low for 3 cycles on the 3rd beat -> `dout`=7'h23, `dout_sel`=2 held stable for 4 cycles; the sequence resumes with no loss or duplicate; `in_ready`=0 throughout.
- Back-to-back frames: second frame (7'h40..7'h45) presented with `in_valid` held high -> accepted on the cycle of the 7'h7F beat; 12 consecutive beats with no gap; `dout_last` on beats 6 and 12.
- Input isolation: change all `din` lanes to 7'h55 and pulse `in_valid` during SEND before the last beat -> output still carries the captured frame; the new data is not accepted.
- Reset mid-frame: assert `reset` after beat 2 -> next cycle `dout_valid`=0. After release, a new frame of 7'h0A.. starts at `dout_sel`=0 with no leftover words.

Source files
------------

// File: rtl/collector_6_to_1_7bits.sv
// collector_6_to_1_7bits: captures six parallel lanes as one frame and replays them
// on a single tagged stream, lane 1 first, with valid/ready on both sides.
module collector_6_to_1_7bits #(
    parameter int DATA_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din_1,
    input  logic [DATA_WIDTH-1:0] din_2,
    input  logic [DATA_WIDTH-1:0] din_3,
    input  logic [DATA_WIDTH-1:0] din_4,
    input  logic [DATA_WIDTH-1:0] din_5,
    input  logic [DATA_WIDTH-1:0] din_6,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            dout_sel,
    output logic                  dout_valid,
    output logic                  dout_last,
    input  logic                  dout_ready
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] cap_q [6];
    logic                  send, accept, beat, at_last;
    // index values 6 and 7 are treated as IDLE so a corrupted index cannot stall the stream
    assign send       = state_q == SEND && idx_q <= 3'd5;
    assign at_last    = send && idx_q == 3'd5;
    assign beat       = send && dout_ready;
    assign in_ready   = !reset && (!send || (at_last && dout_ready));
    assign accept     = in_valid && in_ready;
    assign dout_valid = send;
    assign dout_sel   = send ? idx_q : 3'd0;
    assign dout_last  = at_last;
    always_comb begin
        dout = '0;
        for (int i = 0; i < 6; i++)
            if (send && idx_q == 3'(i)) dout = cap_q[i];
    end
    always_comb begin
        state_d = accept ? SEND : !send ? IDLE : (beat && at_last) ? IDLE : SEND;
        idx_d   = (accept || !send || (beat && at_last)) ? 3'd0 : beat ? idx_q + 3'd1 : idx_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            for (int i = 0; i < 6; i++) cap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                cap_q[0] <= din_1;
                cap_q[1] <= din_2;
                cap_q[2] <= din_3;
                cap_q[3] <= din_4;
                cap_q[4] <= din_5;
                cap_q[5] <= din_6;
            end
        end
    end
endmodule
